// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator (DrawX/DrawY, blank, hs/vs, frame markers)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   FCW      = 8
) (
    input  logic           vga_clk,
    input  logic           reset,
    output logic [9:0]     DrawX,
    output logic [9:0]     DrawY,
    output logic           blank,
    output logic           hs,
    output logic           vs,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_h_max    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_max    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_vis    = 10'(H_VIS);
    localparam logic [9:0] c_v_vis    = 10'(V_VIS);
    localparam logic [9:0] c_hs_begin = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_begin = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_VIS + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_chk
            $error("vga_timing_gen: line/frame totals must not exceed 1024");
        end
    endgenerate

    logic [9:0]     r_hc;
    logic [9:0]     r_vc;
    logic           r_blank;
    logic           r_hs;
    logic           r_vs;
    logic           r_line_start;
    logic           r_frame_start;
    logic [FCW-1:0] r_frame_count;

    logic [9:0]     w_hc_nxt;
    logic [9:0]     w_vc_nxt;
    logic           w_h_wrap;
    logic           w_frame_wrap;

    always_comb begin
        w_h_wrap     = (r_hc == c_h_max);
        w_frame_wrap = w_h_wrap && (r_vc == c_v_max);
        w_hc_nxt     = w_h_wrap ? 10'd0 : r_hc + 10'd1;
        w_vc_nxt     = r_vc;
        if (w_h_wrap) begin
            w_vc_nxt = (r_vc == c_v_max) ? 10'd0 : r_vc + 10'd1;
        end
    end

    // Decode from the next counter values so every flag lines up with the
    // DrawX/DrawY it is registered alongside.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_blank       <= 1'b1;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_blank       <= (w_hc_nxt < c_h_vis) && (w_vc_nxt < c_v_vis);
            r_hs          <= ((w_hc_nxt >= c_hs_begin) && (w_hc_nxt < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
            r_vs          <= ((w_vc_nxt >= c_vs_begin) && (w_vc_nxt < c_vs_end)) ? SYNC_POL : ~SYNC_POL;
            r_line_start  <= (w_hc_nxt == 10'd0);
            r_frame_start <= (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + FCW'(1);
            end
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench: full-size instance for line timing, reduced
//               instance (active-high sync, FCW=2) for frame/vertical timing
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int NCYC      = 2000;
    localparam int MID_RST_K = 1104;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;

    logic [9:0] b_x, b_y;
    logic       b_bl, b_hs, b_vs, b_ls, b_fs;
    logic [7:0] b_fc;
    logic [9:0] s_x, s_y;
    logic       s_bl, s_hs, s_vs, s_ls, s_fs;
    logic [1:0] s_fc;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_big (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(b_x), .DrawY(b_y), .blank(b_bl), .hs(b_hs), .vs(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .FCW(2)
    ) u_small (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(s_x), .DrawY(s_y), .blank(s_bl), .hs(s_hs), .vs(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    typedef struct {
        int         cyc;
        int         seg;
        int         pos;
        bit         big;
        string      name;
        logic [9:0] x, y;
        logic       bl, hs, vs, ls, fs;
        logic [7:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t dir_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference: position is derived arithmetically from clocks since release.
    function automatic exp_t model(input bit big, input bit rst, input int pos, input int k);
        exp_t e;
        int hv, hf, hsn, ht, vv, vf, vsn, vt, fmod, x, y;
        bit pol;
        if (big) begin
            hv = 640; hf = 16; hsn = 96; ht = 800;
            vv = 480; vf = 10; vsn = 2;  vt = 525; pol = 1'b0; fmod = 256;
        end else begin
            hv = 8; hf = 2; hsn = 3; ht = 15;
            vv = 4; vf = 1; vsn = 2; vt = 9; pol = 1'b1; fmod = 4;
        end
        e.cyc = k; e.seg = 0; e.pos = pos; e.big = big;
        e.name = big ? "big_seq" : "small_seq";
        if (rst) begin
            e.x = 10'd0; e.y = 10'd0; e.bl = 1'b1; e.hs = ~pol; e.vs = ~pol;
            e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'd0;
        end else begin
            x = pos % ht;
            y = (pos / ht) % vt;
            e.x  = 10'(x);
            e.y  = 10'(y);
            e.bl = (x < hv) && (y < vv);
            e.hs = (x >= hv + hf && x < hv + hf + hsn) ? pol : ~pol;
            e.vs = (y >= vv + vf && y < vv + vf + vsn) ? pol : ~pol;
            e.ls = (x == 0);
            e.fs = (x == 0) && (y == 0);
            e.fc = 8'((pos / (ht * vt)) % fmod);
        end
        return e;
    endfunction

    task automatic add_dir(input int seg, input int pos, input bit big, input string nm,
                           input int x, input int y, input bit bl, input bit hs, input bit vs,
                           input bit ls, input bit fs, input int fc);
        exp_t e;
        e.cyc = 0; e.seg = seg; e.pos = pos; e.big = big; e.name = nm;
        e.x = 10'(x); e.y = 10'(y); e.bl = bl; e.hs = hs; e.vs = vs;
        e.ls = ls; e.fs = fs; e.fc = 8'(fc);
        dir_q.push_back(e);
    endtask

    // Monitor: every cycle the outputs are valid; pop what was scheduled for it.
    int mon_k = 0;
    always @(negedge vga_clk) begin
        mon_k++;
        while (sb.size() != 0 && sb[0].cyc == mon_k) begin
            exp_t e;
            logic [9:0] ax, ay;
            logic       abl, ahs, avs, als, afs;
            logic [7:0] afc;
            e = sb.pop_front();
            if (e.big) begin
                ax = b_x; ay = b_y; abl = b_bl; ahs = b_hs; avs = b_vs;
                als = b_ls; afs = b_fs; afc = b_fc;
            end else begin
                ax = s_x; ay = s_y; abl = s_bl; ahs = s_hs; avs = s_vs;
                als = s_ls; afs = s_fs; afc = {6'd0, s_fc};
            end
            n_tests++;
            if (ax !== e.x || ay !== e.y || abl !== e.bl || ahs !== e.hs || avs !== e.vs ||
                als !== e.ls || afs !== e.fs || afc !== e.fc) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL %s cyc=%0d got X=%0d Y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want X=%0d Y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                             e.name, mon_k, ax, ay, abl, ahs, avs, als, afs, afc,
                             e.x, e.y, e.bl, e.hs, e.vs, e.ls, e.fs, e.fc);
            end
        end
    end

    initial begin
        int   since;
        int   seg;
        bit   r;
        exp_t e;

        // seg,pos,big,name, x,y, bl,hs,vs,ls,fs,fc
        add_dir(0, 0,    1, "big_reset",      0,   0, 1, 1, 1, 0, 0, 0);
        add_dir(0, 0,    0, "small_reset",    0,   0, 1, 0, 0, 0, 0, 0);
        add_dir(1, 1,    1, "big_first",      1,   0, 1, 1, 1, 0, 0, 0);
        add_dir(1, 639,  1, "big_last_vis",   639, 0, 1, 1, 1, 0, 0, 0);
        add_dir(1, 640,  1, "big_blank_fall", 640, 0, 0, 1, 1, 0, 0, 0);
        add_dir(1, 655,  1, "big_hs_pre",     655, 0, 0, 1, 1, 0, 0, 0);
        add_dir(1, 656,  1, "big_hs_on",      656, 0, 0, 0, 1, 0, 0, 0);
        add_dir(1, 751,  1, "big_hs_last",    751, 0, 0, 0, 1, 0, 0, 0);
        add_dir(1, 752,  1, "big_hs_off",     752, 0, 0, 1, 1, 0, 0, 0);
        add_dir(1, 799,  1, "big_line_end",   799, 0, 0, 1, 1, 0, 0, 0);
        add_dir(1, 800,  1, "big_line_wrap",  0,   1, 1, 1, 1, 1, 0, 0);
        add_dir(1, 0,    1, "big_mid_reset",  0,   0, 1, 1, 1, 0, 0, 0);
        add_dir(2, 1,    1, "big_restart",    1,   0, 1, 1, 1, 0, 0, 0);
        add_dir(1, 1,    0, "small_first",    1,   0, 1, 0, 0, 0, 0, 0);
        add_dir(1, 10,   0, "small_hs_on",    10,  0, 0, 1, 0, 0, 0, 0);
        add_dir(1, 13,   0, "small_hs_off",   13,  0, 0, 0, 0, 0, 0, 0);
        add_dir(1, 15,   0, "small_line",     0,   1, 1, 0, 0, 1, 0, 0);
        add_dir(1, 60,   0, "small_vblank",   0,   4, 0, 0, 0, 1, 0, 0);
        add_dir(1, 75,   0, "small_vs_on",    0,   5, 0, 0, 1, 1, 0, 0);
        add_dir(1, 104,  0, "small_vs_last",  14,  6, 0, 0, 1, 0, 0, 0);
        add_dir(1, 105,  0, "small_vs_off",   0,   7, 0, 0, 0, 1, 0, 0);
        add_dir(1, 135,  0, "small_frame1",   0,   0, 1, 0, 0, 1, 1, 1);
        add_dir(1, 270,  0, "small_frame2",   0,   0, 1, 0, 0, 1, 1, 2);
        add_dir(1, 405,  0, "small_frame3",   0,   0, 1, 0, 0, 1, 1, 3);
        add_dir(1, 540,  0, "small_fc_wrap",  0,   0, 1, 0, 0, 1, 1, 0);
        add_dir(1, 675,  0, "small_frame5",   0,   0, 1, 0, 0, 1, 1, 1);
        add_dir(1, 0,    0, "small_mid_rst",  0,   0, 1, 0, 0, 0, 0, 0);
        add_dir(2, 1,    0, "small_restart",  1,   0, 1, 0, 0, 0, 0, 0);

        since = 0;
        seg   = 0;
        for (int k = 1; k <= NCYC; k++) begin
            // Reset for the first three edges, then one edge mid-frame at (300,1).
            r = (k <= 3) || (k == MID_RST_K);
            reset = r;
            if (r) begin
                since = 0;
            end else begin
                if (since == 0) seg++;
                since++;
            end
            sb.push_back(model(1'b1, r, since, k));
            sb.push_back(model(1'b0, r, since, k));
            foreach (dir_q[i]) begin
                if (dir_q[i].seg == seg && dir_q[i].pos == since) begin
                    e = dir_q[i];
                    e.cyc = k;
                    sb.push_back(e);
                end
            end
            @(posedge vga_clk);
            #1;
        end
        repeat (2) @(negedge vga_clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
